// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: shared widths, boot address, default sizing and queue entry layout.
package fetch_pkg;
   localparam int ADDR_W = 32;
   localparam int INSN_W = 32;
   localparam logic [ADDR_W-1:0] START_ADDRESS = 32'h8002_0000;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_MEM_LAT = 1;
   localparam int ENTRY_W     = ADDR_W + INSN_W;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INSN_W-1:0] insn;
   } fq_entry_t;
endpackage
`default_nettype wire

// File: rtl/insn_fifo.sv
`default_nettype none
// insn_fifo: synchronous power-of-two FIFO with clear; head read straight from storage registers.
module insn_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clr,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_wdata,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_rdata,
   output logic                    o_valid,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_pop;

   assign w_pop = i_pop & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is reset so the head reads zero until the first write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_push && !i_clr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_clr && !w_pop && (r_count == (PW+1)'(DEPTH))));
endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: credit-controlled instruction prefetch buffer between fetch, mainMem and decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req_valid,
   input  logic [ADDR_W-1:0]       i_req_pc,
   input  logic                    i_mem_busy,
   input  logic [INSN_W-1:0]       i_mem_data,
   input  logic                    i_flush,
   input  logic                    i_insn_ready,
   output logic                    o_stall,
   output logic                    o_insn_valid,
   output logic [INSN_W-1:0]       o_insn,
   output logic [ADDR_W-1:0]       o_insn_pc,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + $clog2(MEM_LAT + 1) + 1;

   logic [MEM_LAT-1:0] r_pipe_vld;
   logic [ADDR_W-1:0]  r_pipe_pc [MEM_LAT];

   logic [OW-1:0] w_inflight;
   logic [OW-1:0] w_occupancy;
   logic [CW-1:0] w_count;
   logic          w_accept;
   logic          w_push;
   fq_entry_t     w_wentry;
   fq_entry_t     w_head;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) w_inflight = w_inflight + OW'(r_pipe_vld[i]);
   end

   // Credits count both buffered and in-flight words so a return always has a slot.
   assign w_occupancy = OW'(w_count) + w_inflight;
   assign o_stall     = i_flush | i_mem_busy | (w_occupancy >= OW'(DEPTH));
   assign w_accept    = i_req_valid & ~o_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < MEM_LAT; i++) r_pipe_pc[i] <= '0;
      end else begin
         r_pipe_pc[0] <= i_req_pc;
         for (int i = 1; i < MEM_LAT; i++) r_pipe_pc[i] <= r_pipe_pc[i-1];
         if (i_flush) begin
            r_pipe_vld <= '0;
         end else begin
            r_pipe_vld[0] <= w_accept;
            for (int i = 1; i < MEM_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
         end
      end
   end

   assign w_push        = r_pipe_vld[MEM_LAT-1] & ~i_flush;
   assign w_wentry.pc   = r_pipe_pc[MEM_LAT-1];
   assign w_wentry.insn = i_mem_data;

   insn_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_insn_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_flush),
      .i_push  (w_push),
      .i_wdata (w_wentry),
      .i_pop   (i_insn_ready),
      .o_rdata (w_head),
      .o_valid (o_insn_valid),
      .o_count (w_count)
   );

   assign o_insn    = w_head.insn;
   assign o_insn_pc = w_head.pc;
   assign o_count   = w_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed and randomized traffic checked by a scoreboard of accepted requests.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int DEPTH   = 4;
   localparam int MEM_LAT = 1;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

   typedef struct {
      logic [31:0] pc;
      int          acc;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic [31:0]   req_pc;
   logic          mem_busy;
   logic [31:0]   mem_data;
   logic          flush;
   logic          insn_ready;
   logic          stall;
   logic          insn_valid;
   logic [31:0]   insn;
   logic [31:0]   insn_pc;
   logic [CW-1:0] count;

   req_t        sb_q[$];
   req_t        mem_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [31:0] pc_next;

   fetch_queue #(
      .DEPTH   (DEPTH),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req_valid  (req_valid),
      .i_req_pc     (req_pc),
      .i_mem_busy   (mem_busy),
      .i_mem_data   (mem_data),
      .i_flush      (flush),
      .i_insn_ready (insn_ready),
      .o_stall      (stall),
      .o_insn_valid (insn_valid),
      .o_insn       (insn),
      .o_insn_pc    (insn_pc),
      .o_count      (count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: an entry is buffered once MEM_LAT edges have passed since its acceptance.
   always @(negedge clk) begin
      int   arrived;
      logic exp_stall;
      if (rst_n) begin
         arrived = 0;
         foreach (sb_q[i]) if (sb_q[i].acc + MEM_LAT <= cyc) arrived++;
         exp_stall = flush | mem_busy | (sb_q.size() >= DEPTH);
         chk("count", 64'(count), 64'(arrived));
         chk("insn_valid", 64'(insn_valid), 64'(arrived != 0));
         chk("stall", 64'(stall), 64'(exp_stall));
         if (arrived != 0) begin
            chk("insn_pc", 64'(insn_pc), 64'(sb_q[0].pc));
            chk("insn", 64'(insn), 64'(sb_q[0].pc ^ XOR_KEY));
         end
         if (flush) sb_q.delete();
         else if (arrived != 0 && insn_ready) void'(sb_q.pop_front());
      end
   end

   // One cycle of stimulus; the memory model returns pc^KEY exactly MEM_LAT edges after acceptance.
   task automatic step(input logic rv, input logic busy, input logic fl, input logic rdy);
      logic acc;
      @(posedge clk);
      #1;
      req_valid  = rv;
      req_pc     = pc_next;
      mem_busy   = busy;
      flush      = fl;
      insn_ready = rdy;
      while (mem_q.size() != 0 && mem_q[0].acc + MEM_LAT < cyc + 1) void'(mem_q.pop_front());
      if (mem_q.size() != 0 && mem_q[0].acc + MEM_LAT == cyc + 1) begin
         mem_data = mem_q[0].pc ^ XOR_KEY;
         void'(mem_q.pop_front());
      end else begin
         mem_data = $urandom();
      end
      acc = rv & ~(fl | busy | (sb_q.size() >= DEPTH));
      #6;
      if (acc) begin
         sb_q.push_back('{pc: pc_next, acc: cyc + 1});
         mem_q.push_back('{pc: pc_next, acc: cyc + 1});
         pc_next = pc_next + 32'd4;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3;
      req_valid  = 1'b0;
      mem_busy   = 1'b0;
      flush      = 1'b0;
      insn_ready = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("rst_insn_valid", 64'(insn_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_insn_pc", 64'(insn_pc), 64'd0);
      chk("rst_insn", 64'(insn), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      mem_busy = 1'b1;
      #1;
      chk("rst_stall_busy", 64'(stall), 64'd1);
      mem_busy = 1'b0;
      sb_q.delete();
      mem_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_pc     = '0;
      mem_busy   = 1'b0;
      mem_data   = '0;
      flush      = 1'b0;
      insn_ready = 1'b0;
      pc_next    = START_ADDRESS;
      #2;
      chk("init_insn_valid", 64'(insn_valid), 64'd0);
      chk("init_count", 64'(count), 64'd0);
      chk("init_insn_pc", 64'(insn_pc), 64'd0);
      chk("init_stall", 64'(stall), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Stream of six back-to-back requests with decode always ready.
      pc_next = START_ADDRESS;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Backpressure: only DEPTH requests fit, then drain and resume.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Flush with two buffered and one returning.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      pc_next = 32'h8002_0100;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Memory busy blocks acceptance.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Full queue with simultaneous push and pop.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(5);

      // Reset in the middle of traffic.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      mid_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3,
              $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6);
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
